src_read_sched: RTL and testbench
=================================

Name: src_read_sched

Overview:
- Round-robin scheduler that shares the single 4:1 16-bit register source-select mux among four read requesters (ALU operand A fetch, operand B fetch, store path, debug port).
- Arbitrates requests and drives the mux `sel`.
- Waits a configurable settle time, then captures the mux output `regOut` into a holding register.
- Returns the data to the winner with a valid/ack handshake.
- Sits beside the source-select mux; `sel` connects to its select input and `muxData` connects to its output.

Parameters:
- DATA_WIDTH, 16, width of register data / mux output.
- SETTLE_CYCLES, 1, cycles `sel` is held before capture; legal range 1..7; 0 is illegal and behaves as 1.

Ports:
- logisimClockTree0  input  5  clock tree bus; one clock; all flops update on the rising edge of bit [4]; other bits unused.
- resetN  input  1  synchronous, active-low reset.
- req  input  4  per-requester read request, level.
- reqIdx  input  8  register index per requester; requester i uses [2i+1:2i].
- rdAck  input  4  per-requester acknowledge of returned data.
- sel  output  2  select to the source-select mux.
- muxData  input  DATA_WIDTH  mux output (`regOut`).
- rdData  output  DATA_WIDTH  captured read data.
- rdValid  output  4  one-hot; bit i means `rdData` is valid for requester i.
- grantId  output  2  index of the current or last granted requester.
- busy  output  1  high whenever state is not IDLE.

Behaviour:
- Reset: on any rising edge with resetN=0, the following registered outputs clear to 0: state=IDLE, sel, rdData, rdValid, grantId, settle counter, rrPtr.
  - A reset in mid-transaction aborts it. rdValid is 0 in the cycle after that edge. No data is delivered.
- States: IDLE, SETTLE, RESP.
- IDLE:
  - If req != 0, choose the first set bit scanning from rrPtr upward, mod 4.
  - On that edge: grantId<=winner, sel<=reqIdx[winner], cnt<=SETTLE_CYCLES-1, state<=SETTLE.
  - If req=0, stay in IDLE and hold all registers.
- SETTLE:
  - If cnt!=0: cnt<=cnt-1.
  - If cnt==0: rdData<=muxData, rdValid[grantId]<=1, state<=RESP.
  - SETTLE therefore lasts exactly SETTLE_CYCLES cycles.
- RESP:
  - rdValid and rdData hold until rdAck[grantId]=1 is sampled.
  - On that edge: rdValid<=0, rrPtr<=grantId+1 (wraps 3->0), state<=IDLE.
- Latency:
  - Request sampled in IDLE at edge E; rdValid is first visible after edge E+SETTLE_CYCLES.
  - Minimum IDLE->IDLE turnaround is SETTLE_CYCLES+2 cycles, with ack in the first RESP cycle.
- sel is stable from the grant edge until the next grant. It is never changed in SETTLE, RESP, or idle hold.
- reqIdx is sampled only at the grant edge. Later changes do not affect the in-flight read.
- muxData is sampled only at the last SETTLE edge. Later changes (e.g. a register write) do not alter rdData.
- req rules:
  - req is ignored outside IDLE.
  - Dropping req after the grant does not cancel the transaction; the requester must still ack.
  - A requester still asserting req in the ack cycle is re-arbitrated normally in IDLE. Its priority is lowest because rrPtr has moved past it.
- rdAck rules:
  - rdAck bits other than grantId are ignored.
  - rdAck in IDLE or SETTLE is ignored and not remembered.
- Fairness: with req=4'b1111 held, the grant order is 0,1,2,3,0,...
  - No requester waits more than 3 transactions.
- Simultaneous ack and new request: the ack edge only returns to IDLE. Arbitration happens at the next edge; there is no back-to-back grant inside RESP.
- busy is combinational from state. rdValid, rdData, sel and grantId are registered outputs.

Decomposition:
- Shared package `lalu_pkg`:
  - NR_REQ=4, IDX_WIDTH=2.
  - State localparams ST_IDLE=2'd0, ST_SETTLE=2'd1, ST_RESP=2'd2.
  - ST_3 is unreachable and recovers to IDLE on the next edge.
- One combinational sub-module `rr_pick4`:
  - Inputs req[3:0], ptr[1:0].
  - Outputs any, id[1:0].
  - Rotate, priority-encode, un-rotate.
- The settle counter and FSM stay in the top module.

Test Plan:
- Reset then single read: SETTLE_CYCLES=1, resetN=0 for 2 edges, then req=4'b0001 with reqIdx[1:0]=2'd2 and muxData=16'hBEEF held.
  - sel=2 after edge 1.
  - rdValid=4'b0001 and rdData=16'hBEEF after edge 2.
  - Ack at edge 3 -> rdValid=0, busy=0.
- Round-robin under load: req=4'b1111, reqIdx=8'b11_10_01_00, ack immediately.
  - grantId sequence is 0,1,2,3,0.
  - sel values 0,1,2,3,0.
  - rdData equals each register's value.
- Settle timing: SETTLE_CYCLES=3, muxData changes from 16'h1111 to 16'h2222 one cycle after grant and to 16'h3333 after the capture edge.
  - rdData=16'h2222, captured exactly 3 edges after grant.
- Held response and stray acks: granted requester 2 withholds ack for 5 cycles while rdAck=4'b1011.
  - rdValid stays 4'b0100, sel stays unchanged, rdData stays stable.
  - Ack on bit 2 releases; rrPtr becomes 3 (next grant to 3 when req=4'b1100).
- Reset mid-SETTLE: assert resetN=0 for one edge during SETTLE.
  - Next cycle: state IDLE, sel=0, rdValid=0, rdData=0.
  - A pending req is re-granted from requester 0 priority.

Source files
------------

// File: rtl/lalu_pkg.sv
// rtl/lalu_pkg.sv - shared constants, state encoding and settle-count helper for the read scheduler
package lalu_pkg;

    localparam int NR_REQ    = 4;
    localparam int IDX_WIDTH = 2;
    localparam int CNT_WIDTH = 3;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_RESP   = 2'd2,
        ST_3      = 2'd3
    } state_t;

    // Counter reload value; a settle time of 0 is treated as 1, values above 7 saturate.
    function automatic logic [CNT_WIDTH-1:0] settle_load(input int cycles);
        if (cycles <= 1) begin
            return '0;
        end else if (cycles > 7) begin
            return 3'd6;
        end else begin
            return 3'(cycles - 1);
        end
    endfunction

endpackage

// File: rtl/rr_pick4.sv
// rtl/rr_pick4.sv - combinational round-robin pick: rotate, priority-encode, un-rotate
module rr_pick4
    import lalu_pkg::*;
(
    input  logic [NR_REQ-1:0]    req,
    input  logic [IDX_WIDTH-1:0] ptr,
    output logic                 any,
    output logic [IDX_WIDTH-1:0] id
);

    logic [2*NR_REQ-1:0] dbl;
    logic [NR_REQ-1:0]   rot;
    logic [IDX_WIDTH-1:0] off;

    always_comb begin
        dbl = {req, req} >> ptr;
        rot = dbl[NR_REQ-1:0];
        off = '0;
        // Scan downward so the lowest set bit (nearest to ptr) wins.
        for (int i = NR_REQ - 1; i >= 0; i--) begin
            if (rot[i]) begin
                off = IDX_WIDTH'(i);
            end
        end
        any = |req;
        id  = off + ptr;
    end

endmodule

// File: rtl/src_read_sched.sv
// rtl/src_read_sched.sv - round-robin scheduler sharing the 4:1 register source-select mux among four readers
module src_read_sched
    import lalu_pkg::*;
#(
    parameter int DATA_WIDTH    = 16,
    parameter int SETTLE_CYCLES = 1
) (
    input  logic [4:0]            logisimClockTree0,
    input  logic                  resetN,
    input  logic [3:0]            req,
    input  logic [7:0]            reqIdx,
    input  logic [3:0]            rdAck,
    output logic [1:0]            sel,
    input  logic [DATA_WIDTH-1:0] muxData,
    output logic [DATA_WIDTH-1:0] rdData,
    output logic [3:0]            rdValid,
    output logic [1:0]            grantId,
    output logic                  busy
);

    localparam logic [CNT_WIDTH-1:0] CNT_LOAD = settle_load(SETTLE_CYCLES);

    logic clk;
    logic unused_clk_bits;
    assign clk             = logisimClockTree0[4];
    assign unused_clk_bits = ^logisimClockTree0[3:0];

    state_t                 state, state_nxt;
    logic [1:0]             sel_nxt;
    logic [DATA_WIDTH-1:0]  rd_data_nxt;
    logic [3:0]             rd_valid_nxt;
    logic [1:0]             grant_nxt;
    logic [CNT_WIDTH-1:0]   cnt, cnt_nxt;
    logic [1:0]             rr_ptr, rr_ptr_nxt;

    logic                   pick_any;
    logic [1:0]             pick_id;
    logic [7:0]             idx_sh;
    logic                   ack_hit;

    rr_pick4 u_pick (
        .req (req),
        .ptr (rr_ptr),
        .any (pick_any),
        .id  (pick_id)
    );

    assign idx_sh  = reqIdx >> {pick_id, 1'b0};
    assign ack_hit = rdAck[grantId];
    assign busy    = (state != ST_IDLE);

    always_comb begin
        state_nxt    = state;
        sel_nxt      = sel;
        rd_data_nxt  = rdData;
        rd_valid_nxt = rdValid;
        grant_nxt    = grantId;
        cnt_nxt      = cnt;
        rr_ptr_nxt   = rr_ptr;
        case (state)
            ST_IDLE: begin
                if (pick_any) begin
                    grant_nxt = pick_id;
                    sel_nxt   = idx_sh[1:0];
                    cnt_nxt   = CNT_LOAD;
                    state_nxt = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (cnt != '0) begin
                    cnt_nxt = cnt - 3'd1;
                end else begin
                    rd_data_nxt  = muxData;
                    rd_valid_nxt = 4'b0001 << grantId;
                    state_nxt    = ST_RESP;
                end
            end
            ST_RESP: begin
                // Ack only returns to IDLE; arbitration waits for the next edge.
                if (ack_hit) begin
                    rd_valid_nxt = '0;
                    rr_ptr_nxt   = grantId + 2'd1;
                    state_nxt    = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetN) begin
            state   <= ST_IDLE;
            sel     <= '0;
            rdData  <= '0;
            rdValid <= '0;
            grantId <= '0;
            cnt     <= '0;
            rr_ptr  <= '0;
        end else begin
            state   <= state_nxt;
            sel     <= sel_nxt;
            rdData  <= rd_data_nxt;
            rdValid <= rd_valid_nxt;
            grantId <= grant_nxt;
            cnt     <= cnt_nxt;
            rr_ptr  <= rr_ptr_nxt;
        end
    end

endmodule

// File: tb/tb_src_read_sched.sv
// tb/tb_src_read_sched.sv - randomized transaction-level bench for src_read_sched (settle 1, 3 and 0)
module tb_src_read_sched;

    localparam int ND = 3;

    logic        clk;
    logic        rstn   [ND];
    logic [3:0]  req_i  [ND];
    logic [7:0]  idx_i  [ND];
    logic [3:0]  ack_i  [ND];
    logic [15:0] mux_i  [ND];
    logic [1:0]  sel_o  [ND];
    logic [15:0] data_o [ND];
    logic [3:0]  vld_o  [ND];
    logic [1:0]  gnt_o  [ND];
    logic        busy_o [ND];

    int eff_settle [ND] = '{1, 3, 1};
    int ptr        [ND];
    logic [1:0] last_sel [ND];

    int checks = 0;
    int failures = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < ND; g++) begin : g_dut
        localparam int SC = (g == 0) ? 1 : (g == 1) ? 3 : 0;
        src_read_sched #(.DATA_WIDTH(16), .SETTLE_CYCLES(SC)) u_dut (
            .logisimClockTree0 ({clk, 4'b0000}),
            .resetN            (rstn[g]),
            .req               (req_i[g]),
            .reqIdx            (idx_i[g]),
            .rdAck             (ack_i[g]),
            .sel               (sel_o[g]),
            .muxData           (mux_i[g]),
            .rdData            (data_o[g]),
            .rdValid           (vld_o[g]),
            .grantId           (gnt_o[g]),
            .busy              (busy_o[g])
        );
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int rr_winner(input int p, input logic [3:0] rq);
        for (int k = 0; k < 4; k++) begin
            if (rq[(p + k) % 4]) return (p + k) % 4;
        end
        return -1;
    endfunction

    task automatic do_reset(input int d, input int n);
        rstn[d] = 1'b0;
        for (int i = 0; i < n; i++) step();
        check("rst_sel", sel_o[d], 0);
        check("rst_data", data_o[d], 0);
        check("rst_vld", vld_o[d], 0);
        check("rst_gnt", gnt_o[d], 0);
        check("rst_busy", busy_o[d], 0);
        rstn[d] = 1'b1;
        ptr[d] = 0;
        last_sel[d] = 2'd0;
    endtask

    task automatic idle_cycles(input int d, input int n);
        req_i[d] = 4'b0;
        for (int i = 0; i < n; i++) begin
            ack_i[d] = 4'($urandom);
            step();
            check("idle_busy", busy_o[d], 0);
            check("idle_sel", sel_o[d], last_sel[d]);
            check("idle_vld", vld_o[d], 0);
        end
        ack_i[d] = 4'b0;
    endtask

    task automatic run_txn(input int d, input logic [3:0] rq, input logic [7:0] ix,
                           input int hold, input int abort_at);
        int w;
        logic [1:0] es;
        logic [7:0] ixs;
        logic [15:0] ed;
        w = rr_winner(ptr[d], rq);
        ixs = ix >> (2 * w);
        es = ixs[1:0];
        req_i[d] = rq;
        idx_i[d] = ix;
        ack_i[d] = 4'b0;
        mux_i[d] = 16'($urandom);
        step();
        check("grant_id", gnt_o[d], w);
        check("grant_sel", sel_o[d], es);
        check("grant_busy", busy_o[d], 1);
        check("grant_vld", vld_o[d], 0);
        req_i[d] = 4'($urandom);
        idx_i[d] = 8'($urandom);
        ed = '0;
        for (int k = 0; k < eff_settle[d]; k++) begin
            mux_i[d] = 16'($urandom);
            ed = mux_i[d];
            ack_i[d] = 4'($urandom);
            if (k == abort_at) begin
                rstn[d] = 1'b0;
                step();
                rstn[d] = 1'b1;
                check("abort_sel", sel_o[d], 0);
                check("abort_vld", vld_o[d], 0);
                check("abort_data", data_o[d], 0);
                check("abort_busy", busy_o[d], 0);
                ptr[d] = 0;
                last_sel[d] = 2'd0;
                req_i[d] = 4'b0;
                ack_i[d] = 4'b0;
                return;
            end
            step();
            if (k < eff_settle[d] - 1) begin
                check("settle_vld", vld_o[d], 0);
                check("settle_sel", sel_o[d], es);
            end
        end
        check("cap_vld", vld_o[d], 32'(4'b0001 << w));
        check("cap_data", data_o[d], ed);
        check("cap_gnt", gnt_o[d], w);
        mux_i[d] = 16'($urandom);
        for (int h = 0; h < hold; h++) begin
            ack_i[d] = 4'($urandom) & ~(4'b0001 << w);
            req_i[d] = 4'($urandom);
            step();
            check("hold_vld", vld_o[d], 32'(4'b0001 << w));
            check("hold_data", data_o[d], ed);
            check("hold_sel", sel_o[d], es);
            check("hold_busy", busy_o[d], 1);
        end
        ack_i[d] = 4'($urandom) | (4'b0001 << w);
        step();
        check("ack_vld", vld_o[d], 0);
        check("ack_busy", busy_o[d], 0);
        check("ack_sel", sel_o[d], es);
        ptr[d] = (w + 1) % 4;
        last_sel[d] = es;
        req_i[d] = 4'b0;
        ack_i[d] = 4'b0;
    endtask

    initial begin
        logic [3:0] rq;
        int d;
        int ab;
        for (int i = 0; i < ND; i++) begin
            rstn[i] = 1'b0;
            req_i[i] = '0;
            idx_i[i] = '0;
            ack_i[i] = '0;
            mux_i[i] = '0;
            ptr[i] = 0;
            last_sel[i] = '0;
        end
        for (int i = 0; i < ND; i++) do_reset(i, 2);

        // single read, then round-robin under full load
        run_txn(0, 4'b0001, 8'b0000_0010, 0, -1);
        idle_cycles(0, 2);
        for (int i = 0; i < 5; i++) run_txn(0, 4'b1111, 8'b11_10_01_00, 0, -1);

        // held response with stray acks, then pointer moves past requester 2
        run_txn(0, 4'b0100, 8'($urandom), 5, -1);
        run_txn(0, 4'b1100, 8'($urandom), 0, -1);

        // longer settle and the illegal-zero settle instance
        run_txn(1, 4'b0010, 8'($urandom), 0, -1);
        run_txn(1, 4'b1111, 8'($urandom), 3, -1);
        run_txn(2, 4'b1000, 8'($urandom), 1, -1);

        // reset in mid-SETTLE, then re-grant from requester 0 priority
        run_txn(1, 4'b1111, 8'($urandom), 0, 1);
        run_txn(1, 4'b1111, 8'($urandom), 0, -1);
        run_txn(0, 4'b0110, 8'($urandom), 0, 0);
        run_txn(0, 4'b1111, 8'($urandom), 0, -1);

        for (int n = 0; n < 80; n++) begin
            d = int'($urandom_range(0, ND - 1));
            rq = 4'($urandom_range(1, 15));
            ab = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, eff_settle[d] - 1)) : -1;
            run_txn(d, rq, 8'($urandom), int'($urandom_range(0, 3)), ab);
            idle_cycles(d, int'($urandom_range(0, 2)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
